// File: rtl/ddc_pkg.sv
// Shared widths and the saturating clamp for the DDC mixer and decimation chain.
// Width helpers only; no registers and no flow control.
// The clamp is width-generic through its argument, so one copy serves every stage.
package ddc_pkg;

  localparam int ADW_DEF = 16;
  localparam int MPR_DEF = 17;
  localparam int OW_DEF  = 24;
  localparam int PW_DEF  = ADW_DEF + MPR_DEF;
  localparam int SH_DEF  = PW_DEF - 1 - OW_DEF;

  // Clamp a sign-extended value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/ddc_round_sat.sv
// Optional negate, round-half-up by SH bits, then saturate to OW bits.
// Latency: combinational; the parent registers y and sat.
// Backpressure: none; follows whatever the parent presents.
module ddc_round_sat
  import ddc_pkg::*;
#(
  parameter int IW = PW_DEF,
  parameter int OW = OW_DEF,
  parameter int SH = SH_DEF
) (
  input  logic signed [IW-1:0] p,
  input  logic                 neg,
  output logic signed [OW-1:0] y,
  output logic                 sat
);

  // Two guard bits: one makes -(-2^(IW-1)) exact, one absorbs the rounding carry.
  localparam logic signed [IW+1:0] RND = {{(IW+1){1'b0}}, 1'b1} << (SH - 1);

  logic signed [IW+1:0] ext;
  logic signed [IW+1:0] nv;
  logic signed [IW+1:0] sum;
  logic signed [IW+1:0] shv;
  logic signed [63:0]   wide;
  logic signed [63:0]   clamped;

  always_comb begin
    ext     = {{2{p[IW-1]}}, p};
    nv      = neg ? -ext : ext;
    sum     = nv + RND;
    shv     = sum >>> SH;
    wide    = {{(64-IW-2){shv[IW+1]}}, shv};
    clamped = sat_clamp(wide, OW);
    y       = clamped[OW-1:0];
    sat     = (clamped != wide);
  end

endmodule

// File: rtl/ddc_quad_mixer.sv
// Real ADC stream times NCO cos/sin into complex baseband: I = adc*cos, Q = -adc*sin.
// Latency: 3 + ADC_DLY clken cycles from adc_i to i_o/q_o.
// Backpressure: none; clken low freezes the whole pipe, nco_valid low discards samples.
module ddc_quad_mixer
  import ddc_pkg::*;
#(
  parameter int ADW     = ADW_DEF,
  parameter int MPR     = MPR_DEF,
  parameter int OW      = OW_DEF,
  parameter int ADC_DLY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic signed [ADW-1:0] adc_i,
  input  logic                  adc_valid,
  input  logic signed [MPR-1:0] nco_sin,
  input  logic signed [MPR-1:0] nco_cos,
  input  logic                  nco_valid,
  input  logic                  ovf_clr,
  output logic signed [OW-1:0]  i_o,
  output logic signed [OW-1:0]  q_o,
  output logic                  out_valid,
  output logic                  sat_o,
  output logic                  ovf_sticky
);

  localparam int PW = ADW + MPR;
  localparam int SH = PW - 1 - OW;

  if (SH < 1) begin : g_sh_check
    $error("ddc_quad_mixer: ADW+MPR-1-OW must be at least 1");
  end
  if (ADC_DLY < 0 || ADC_DLY > 15) begin : g_dly_check
    $error("ddc_quad_mixer: ADC_DLY must be within 0..15");
  end

  logic signed [ADW-1:0] adc_d;
  logic                  adc_d_vld;

  if (ADC_DLY == 0) begin : g_nodly
    assign adc_d     = adc_i;
    assign adc_d_vld = adc_valid;
  end else begin : g_dly
    logic signed [ADW-1:0] dly_dat [ADC_DLY];
    logic [ADC_DLY-1:0]    dly_vld;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < ADC_DLY; k++) dly_dat[k] <= '0;
        dly_vld <= '0;
      end else if (clken) begin
        dly_dat[0] <= adc_i;
        dly_vld[0] <= adc_valid;
        for (int k = 1; k < ADC_DLY; k++) begin
          dly_dat[k] <= dly_dat[k-1];
          dly_vld[k] <= dly_vld[k-1];
        end
      end
    end

    assign adc_d     = dly_dat[ADC_DLY-1];
    assign adc_d_vld = dly_vld[ADC_DLY-1];
  end

  logic signed [ADW-1:0] s0_adc;
  logic signed [MPR-1:0] s0_sin;
  logic signed [MPR-1:0] s0_cos;
  logic                  v0;
  logic signed [PW-1:0]  p_i;
  logic signed [PW-1:0]  p_q;
  logic                  v1;
  logic signed [PW-1:0]  adc_x;
  logic signed [PW-1:0]  sin_x;
  logic signed [PW-1:0]  cos_x;
  logic signed [OW-1:0]  ri;
  logic signed [OW-1:0]  rq;
  logic                  sat_i;
  logic                  sat_q;
  logic                  sat_nxt;

  // Full product fits PW bits, so truncating the sign-extended multiply is exact.
  assign adc_x   = {{MPR{s0_adc[ADW-1]}}, s0_adc};
  assign sin_x   = {{ADW{s0_sin[MPR-1]}}, s0_sin};
  assign cos_x   = {{ADW{s0_cos[MPR-1]}}, s0_cos};
  assign sat_nxt = v1 & (sat_i | sat_q);

  ddc_round_sat #(.IW(PW), .OW(OW), .SH(SH)) u_rs_i (
    .p   (p_i),
    .neg (1'b0),
    .y   (ri),
    .sat (sat_i)
  );

  ddc_round_sat #(.IW(PW), .OW(OW), .SH(SH)) u_rs_q (
    .p   (p_q),
    .neg (1'b1),
    .y   (rq),
    .sat (sat_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_adc     <= '0;
      s0_sin     <= '0;
      s0_cos     <= '0;
      v0         <= 1'b0;
      p_i        <= '0;
      p_q        <= '0;
      v1         <= 1'b0;
      i_o        <= '0;
      q_o        <= '0;
      sat_o      <= 1'b0;
      out_valid  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (clken) begin
      s0_adc     <= adc_d;
      s0_sin     <= nco_sin;
      s0_cos     <= nco_cos;
      v0         <= adc_d_vld & nco_valid;
      p_i        <= adc_x * cos_x;
      p_q        <= adc_x * sin_x;
      v1         <= v0;
      i_o        <= ri;
      q_o        <= rq;
      sat_o      <= sat_nxt;
      out_valid  <= v1;
      // A new saturation wins over a simultaneous clear.
      ovf_sticky <= sat_nxt | (ovf_sticky & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_ddc_quad_mixer.sv
// Bench for ddc_quad_mixer: vector table and ramp checked through an expected-result queue,
// plus hand sequences for latency, sticky overflow, clken stalls and mid-stream reset.
module tb_ddc_quad_mixer;

  logic               clk = 1'b0;
  logic               reset;
  logic               clken;
  logic signed [15:0] adc;
  logic               adc_valid;
  logic signed [16:0] nco_sin;
  logic signed [16:0] nco_cos;
  logic               nco_valid;
  logic               ovf_clr;
  logic signed [23:0] i_o;
  logic signed [23:0] q_o;
  logic               out_valid;
  logic               sat_o;
  logic               ovf_sticky;
  logic signed [23:0] i4;
  logic signed [23:0] q4;
  logic               v4;
  logic               s4;
  logic               o4;

  always #5 clk = ~clk;

  ddc_quad_mixer dut (
    .clk(clk), .reset(reset), .clken(clken), .adc_i(adc), .adc_valid(adc_valid),
    .nco_sin(nco_sin), .nco_cos(nco_cos), .nco_valid(nco_valid), .ovf_clr(ovf_clr),
    .i_o(i_o), .q_o(q_o), .out_valid(out_valid), .sat_o(sat_o), .ovf_sticky(ovf_sticky)
  );

  ddc_quad_mixer #(.ADC_DLY(4)) dut4 (
    .clk(clk), .reset(reset), .clken(clken), .adc_i(adc), .adc_valid(adc_valid),
    .nco_sin(nco_sin), .nco_cos(nco_cos), .nco_valid(nco_valid), .ovf_clr(ovf_clr),
    .i_o(i4), .q_o(q4), .out_valid(v4), .sat_o(s4), .ovf_sticky(o4)
  );

  typedef struct {int i; int q; bit sat;} exp_t;
  typedef struct {int a; int s; int c; int ei; int eq; bit es;} vec_t;

  exp_t sbq[$];
  vec_t tab[10];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int s, input int c);
    exp_t   r;
    longint pi, pq, ri, rq;
    pi = longint'(a) * longint'(c);
    pq = longint'(a) * longint'(s);
    ri = (pi + 128) >>> 8;
    rq = (-pq + 128) >>> 8;
    r.sat = 1'b0;
    if (ri > 8388607)  begin ri = 8388607;  r.sat = 1'b1; end
    if (ri < -8388608) begin ri = -8388608; r.sat = 1'b1; end
    if (rq > 8388607)  begin rq = 8388607;  r.sat = 1'b1; end
    if (rq < -8388608) begin rq = -8388608; r.sat = 1'b1; end
    r.i = int'(ri);
    r.q = int'(rq);
    return r;
  endfunction

  task automatic drive(input bit ce, input bit av, input bit nv, input int a, input int s, input int c);
    @(negedge clk);
    clken     = ce;
    adc_valid = av;
    nco_valid = nv;
    adc       = 16'(a);
    nco_sin   = 17'(s);
    nco_cos   = 17'(c);
    if (ce && av && nv) sbq.push_back(model(a, s, c));
  endtask

  // Single valid sample; counts clken edges until the chosen instance raises out_valid.
  task automatic measure(input bit four, input int a, input int s, input int c,
                         input int exp_lat, input int exp_i);
    int lat;
    bit seen;
    drive(1, 1, 1, a, s, c);
    lat  = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #2;
      if (k == 0) adc_valid = 1'b0;
      lat++;
      if (four ? v4 : out_valid) seen = 1;
    end
    chk(four ? "latency_dly4" : "latency", seen ? lat : -1, exp_lat);
    chk(four ? "lat_i_dly4" : "lat_i", four ? i4 : i_o, exp_i);
    chk(four ? "lat_q_dly4" : "lat_q", four ? q4 : q_o, 0);
    @(posedge clk);
    #2;
    chk(four ? "valid_pulse_dly4" : "valid_pulse", four ? v4 : out_valid, 0);
  endtask

  // Output monitor: pops one expectation per produced sample, checks hold under clken=0.
  bit mon_ce, mon_rst;
  int prev_i, prev_q;
  bit prev_v, prev_s;
  exp_t me;

  always @(posedge clk) begin
    mon_ce  = clken;
    mon_rst = reset;
    #1;
    if (!mon_rst && mon_ce && out_valid) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: out_valid=1 with i=%0d q=%0d, expected no sample (t=%0t)",
                 i_o, q_o, $time);
      end else begin
        me = sbq.pop_front();
        chk("i_o", i_o, me.i);
        chk("q_o", q_o, me.q);
        chk("sat_o", sat_o, me.sat);
      end
    end
    if (!mon_rst && !mon_ce) begin
      chk("hold_i", i_o, prev_i);
      chk("hold_q", q_o, prev_q);
      chk("hold_valid", out_valid, prev_v);
      chk("hold_sat", sat_o, prev_s);
    end
    prev_i = i_o;
    prev_q = q_o;
    prev_v = out_valid;
    prev_s = sat_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int a, s, c;
    bit ce, nv;

    tab[0] = '{16384,  0,      65535,  4194240,  0,        1'b0};
    tab[1] = '{-32768, 0,      -65536, 8388607,  0,        1'b1};
    tab[2] = '{-32768, 65535,  0,      0,        8388480,  1'b0};
    tab[3] = '{1,      -128,   0,      0,        1,        1'b0};
    tab[4] = '{1,      0,      128,    1,        0,        1'b0};
    tab[5] = '{1,      0,      127,    0,        0,        1'b0};
    tab[6] = '{-1,     0,      128,    0,        0,        1'b0};
    tab[7] = '{-1,     0,      129,    -1,       0,        1'b0};
    tab[8] = '{32767,  65535,  65535,  8388224,  -8388224, 1'b0};
    tab[9] = '{-32768, -65536, 0,      0,        -8388608, 1'b0};

    reset = 1'b1; clken = 1'b1; adc = '0; adc_valid = 1'b0;
    nco_sin = '0; nco_cos = '0; nco_valid = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_i", i_o, 0);
    chk("rst_q", q_o, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_sticky", ovf_sticky, 0);
    reset = 1'b0;

    measure(0, 16384, 0, 65535, 3, 4194240);

    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      clken = 1'b1; adc_valid = 1'b1; nco_valid = 1'b1;
      adc = 16'(tab[n].a); nco_sin = 17'(tab[n].s); nco_cos = 17'(tab[n].c);
      sbq.push_back('{tab[n].ei, tab[n].eq, tab[n].es});
    end
    repeat (5) drive(1, 0, 1, 0, 0, 0);
    chk("sticky_held", ovf_sticky, 1);

    drive(1, 0, 1, 0, 0, 0);
    ovf_clr = 1'b1;
    @(posedge clk);
    #2;
    chk("sticky_cleared", ovf_sticky, 0);
    ovf_clr = 1'b0;

    // Clear lands on the same edge that registers a saturated sample.
    drive(1, 1, 1, -32768, 0, -65536);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    ovf_clr = 1'b1;
    @(posedge clk);
    #2;
    chk("sat_pulse_clr_edge", sat_o, 1);
    chk("sticky_set_wins", ovf_sticky, 1);
    ovf_clr = 1'b0;
    drive(1, 0, 1, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("sat_pulse_end", sat_o, 0);
    chk("sticky_after", ovf_sticky, 1);

    for (int k = 0; k < 30; k++) begin
      a = k * 2000 - 30000;
      c = 65535 - k * 4500;
      s = k * 4400 - 65000;
      if (k == 5) begin a = -32768; c = -65536; end
      ce = !(k >= 10 && k < 15);
      nv = !(k >= 20 && k < 24);
      drive(ce, (k % 7) != 3, nv, a, s, c);
    end
    repeat (5) drive(1, 0, 1, 0, 0, 0);
    chk("ramp_drained", sbq.size(), 0);

    drive(1, 1, 1, 1000, 2000, 3000);
    drive(1, 1, 1, -2000, 5000, -7000);
    drive(1, 1, 1, 3000, -9000, 11000);
    @(negedge clk);
    reset = 1'b1;
    adc_valid = 1'b0;
    sbq.delete();
    @(posedge clk);
    #2;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_i", i_o, 0);
    chk("midrst_q", q_o, 0);
    chk("midrst_sat", sat_o, 0);
    chk("midrst_sticky", ovf_sticky, 0);
    chk("midrst_valid_dly4", v4, 0);
    chk("midrst_sticky_dly4", o4, 0);
    reset = 1'b0;

    measure(0, 16384, 0, 65535, 3, 4194240);
    repeat (8) drive(1, 0, 1, 0, 0, 0);
    measure(1, 16384, 0, 65535, 7, 4194240);
    chk("sat_dly4", s4, 0);
    repeat (8) drive(1, 0, 1, 0, 0, 0);
    chk("final_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
